// File: rtl/break_ctrl.sv
// Host debug controller for the break unit: config registers, halt/continue
// sequencing, and hit-count breakpoints that auto-continue a set number of times.
module break_ctrl #(
  parameter int CONT_CYCLES = 2,
  parameter int HIT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  input  logic        reg_we,
  input  logic        reg_re,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  input  logic        stop_clk,
  output logic [31:0] inst_break,
  output logic [31:0] data_break,
  output logic        inst_break_pc_en,
  output logic        inst_break_en,
  output logic        data_break_rd_en,
  output logic        data_break_wr_en,
  output logic        break_continue,
  output logic        halt_irq
);

  localparam int CW = (CONT_CYCLES > 2) ? $clog2(CONT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CONT_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    CONT   = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      ctrl;
  logic [HIT_W-1:0] skip_reload;
  logic [HIT_W-1:0] skip_rem;
  logic [HIT_W-1:0] hit_count;
  logic            cont_fail;
  logic [CW-1:0]   cont_cnt;
  logic            seen_low;

  logic [31:0] rd_mux;
  logic [15:0] hits16;
  logic        cmd_go;

  assign inst_break_pc_en = ctrl[0];
  assign inst_break_en    = ctrl[1];
  assign data_break_rd_en = ctrl[2];
  assign data_break_wr_en = ctrl[3];

  assign hits16 = 16'(hit_count);
  assign cmd_go = reg_we && (reg_addr == 3'd4) && reg_wdata[0];

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      3'd0: rd_mux = {28'b0, ctrl};
      3'd1: rd_mux = inst_break;
      3'd2: rd_mux = data_break;
      3'd3: rd_mux = 32'(skip_reload);
      3'd5: rd_mux = {hits16, 13'b0,
                      state == CONT,
                      cont_fail,
                      state == HALTED};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      ctrl           <= '0;
      inst_break     <= '0;
      data_break     <= '0;
      skip_reload    <= '0;
      skip_rem       <= '0;
      hit_count      <= '0;
      cont_fail      <= 1'b0;
      cont_cnt       <= '0;
      seen_low       <= 1'b0;
      break_continue <= 1'b0;
      halt_irq       <= 1'b0;
      reg_rdata      <= '0;
      reg_rvalid     <= 1'b0;
    end else begin
      halt_irq   <= 1'b0;
      reg_rvalid <= reg_re;
      if (reg_re)
        reg_rdata <= rd_mux;

      case (state)
        RUN: begin
          if (stop_clk) begin
            if (hit_count != '1)
              hit_count <= hit_count + 1'b1;
            if (skip_rem != '0) begin
              skip_rem       <= skip_rem - 1'b1;
              state          <= CONT;
              break_continue <= 1'b1;
              cont_cnt       <= '0;
              seen_low       <= 1'b0;
            end else begin
              state    <= HALTED;
              halt_irq <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (cmd_go) begin
            skip_rem       <= skip_reload;
            state          <= CONT;
            break_continue <= 1'b1;
            cont_cnt       <= '0;
            seen_low       <= 1'b0;
          end
        end
        CONT: begin
          // stop_clk must drop at least once, or the core never resumed
          if (cont_cnt == CNT_LAST) begin
            break_continue <= 1'b0;
            if (seen_low || !stop_clk) begin
              state <= RUN;
            end else begin
              cont_fail <= 1'b1;
              state     <= HALTED;
              halt_irq  <= 1'b1;
            end
          end else begin
            cont_cnt <= cont_cnt + 1'b1;
            seen_low <= seen_low | ~stop_clk;
          end
        end
        default: begin
          state          <= RUN;
          break_continue <= 1'b0;
        end
      endcase

      // host writes land after the hit evaluation above
      if (reg_we) begin
        case (reg_addr)
          3'd0: ctrl       <= reg_wdata[3:0];
          3'd1: inst_break <= reg_wdata;
          3'd2: data_break <= reg_wdata;
          3'd3: begin
            skip_reload <= reg_wdata[HIT_W-1:0];
            skip_rem    <= reg_wdata[HIT_W-1:0];
          end
          3'd5: begin
            cont_fail <= 1'b0;
            hit_count <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_break_ctrl.sv
// Bench for break_ctrl: register table, directed halt/continue sequences,
// and random traffic against a behavioural model with a simple break-unit stub.
module tb_break_ctrl;

  localparam int CONT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic        stop_clk;
  logic [31:0] inst_break;
  logic [31:0] data_break;
  logic        inst_break_pc_en;
  logic        inst_break_en;
  logic        data_break_rd_en;
  logic        data_break_wr_en;
  logic        break_continue;
  logic        halt_irq;

  break_ctrl #(.CONT_CYCLES(CONT_CYCLES), .HIT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we(reg_we),
    .reg_re(reg_re),
    .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid),
    .stop_clk(stop_clk),
    .inst_break(inst_break),
    .data_break(data_break),
    .inst_break_pc_en(inst_break_pc_en),
    .inst_break_en(inst_break_en),
    .data_break_rd_en(data_break_rd_en),
    .data_break_wr_en(data_break_wr_en),
    .break_continue(break_continue),
    .halt_irq(halt_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: mode 0 run, 1 halted, 2 continuing
  int          m_mode;
  int          m_left;
  bit          m_low;
  logic [3:0]  m_ctrl;
  logic [31:0] m_ib, m_db;
  logic [15:0] m_skip, m_rem, m_hits;
  bit          m_fail, m_irq, m_rvalid;
  logic [31:0] m_rdata;

  bit rel_en;
  bit prev_bc;
  int n_bc, n_irq;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [2:0] a);
    case (a)
      3'd0: return {28'b0, m_ctrl};
      3'd1: return m_ib;
      3'd2: return m_db;
      3'd3: return {16'b0, m_skip};
      3'd5: return {m_hits, 13'b0, m_mode == 2, m_fail, m_mode == 1};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_left = 0; m_low = 0;
      m_ctrl = 0; m_ib = 0; m_db = 0;
      m_skip = 0; m_rem = 0; m_hits = 0;
      m_fail = 0; m_irq = 0; m_rvalid = 0; m_rdata = 0;
      return;
    end
    if (reg_re) m_rdata = mread(reg_addr);
    m_rvalid = reg_re;
    m_irq = 0;
    if (m_mode == 0) begin
      if (stop_clk) begin
        if (m_hits != 16'hFFFF) m_hits++;
        if (m_rem != 0) begin
          m_rem--; m_mode = 2; m_left = CONT_CYCLES; m_low = 0;
        end else begin
          m_mode = 1; m_irq = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (reg_we && reg_addr == 3'd4 && reg_wdata[0]) begin
        m_rem = m_skip; m_mode = 2; m_left = CONT_CYCLES; m_low = 0;
      end
    end else begin
      if (!stop_clk) m_low = 1;
      m_left--;
      if (m_left == 0) begin
        if (m_low) m_mode = 0;
        else begin
          m_fail = 1; m_mode = 1; m_irq = 1;
        end
      end
    end
    if (reg_we) begin
      case (reg_addr)
        3'd0: m_ctrl = reg_wdata[3:0];
        3'd1: m_ib = reg_wdata;
        3'd2: m_db = reg_wdata;
        3'd3: begin m_skip = reg_wdata[15:0]; m_rem = reg_wdata[15:0]; end
        3'd5: begin m_fail = 0; m_hits = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    chk("ctl",
        {57'b0, break_continue, halt_irq, reg_rvalid,
         data_break_wr_en, data_break_rd_en, inst_break_en,
         inst_break_pc_en},
        {57'b0, m_mode == 2, m_irq, m_rvalid, m_ctrl});
    chk("rdata", {32'b0, reg_rdata}, {32'b0, m_rdata});
    chk("addrs", {inst_break, data_break}, {m_ib, m_db});
    if (break_continue) n_bc++;
    if (halt_irq) n_irq++;
    // break unit stub: stop_clk falls one cycle after continue rises
    if (rel_en && prev_bc) stop_clk = 1'b0;
    prev_bc = break_continue;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    cycle();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    reg_addr = a; reg_re = 1'b1;
    cycle();
    reg_re = 1'b0;
    chk("rd_rvalid", {63'b0, reg_rvalid}, 64'd1);
    d = reg_rdata;
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;

    tbl[0] = '{3'd0, 32'hFFFF_FFF5, 32'h0000_0005};
    tbl[1] = '{3'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[2] = '{3'd2, 32'h1234_5678, 32'h1234_5678};
    tbl[3] = '{3'd3, 32'hABCD_0002, 32'h0000_0002};
    tbl[4] = '{3'd3, 32'hFFFF_0000, 32'h0000_0000};
    tbl[5] = '{3'd4, 32'h0000_0001, 32'h0000_0000};
    tbl[6] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[7] = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[8] = '{3'd7, 32'h0000_1234, 32'h0000_0000};

    reset = 1'b1; reg_addr = 0; reg_wdata = 0;
    reg_we = 0; reg_re = 0; stop_clk = 0;
    rel_en = 1; prev_bc = 0;
    cycle(); cycle();
    reset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk("reset_rd", {32'b0, d}, 64'd0);
    end

    for (int i = 0; i < 9; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, d);
      chk("tbl_rd", {32'b0, d}, {32'b0, tbl[i].rexp});
    end

    // halt on first hit
    wr(3'd0, 32'h1);
    chk("pc_en", {63'b0, inst_break_pc_en}, 64'd1);
    wr(3'd1, 32'h100);
    chk("inst_break", {32'b0, inst_break}, 64'h100);
    n_irq = 0;
    stop_clk = 1;
    repeat (4) cycle();
    chk("halt_irq_cnt", 64'(n_irq), 64'd1);
    rd(3'd5, d);
    chk("status_halt", {32'b0, d}, 64'h0001_0001);

    // host continue
    n_bc = 0;
    wr(3'd4, 32'h1);
    repeat (4) cycle();
    chk("bc_cycles", 64'(n_bc), 64'd2);
    rd(3'd5, d);
    chk("status_run", {32'b0, d}, 64'h0001_0000);

    // hit-count breakpoint
    wr(3'd5, 32'h0);
    wr(3'd3, 32'h3);
    n_irq = 0; n_bc = 0;
    for (int k = 0; k < 3; k++) begin
      stop_clk = 1;
      repeat (4) cycle();
    end
    chk("skip_no_irq", 64'(n_irq), 64'd0);
    chk("skip_bc", 64'(n_bc), 64'd6);
    stop_clk = 1;
    repeat (3) cycle();
    chk("skip_halt_irq", 64'(n_irq), 64'd1);
    rd(3'd5, d);
    chk("status_hits4", {32'b0, d}, 64'h0004_0001);
    wr(3'd4, 32'h1);
    repeat (3) cycle();
    n_irq = 0;
    stop_clk = 1;
    repeat (4) cycle();
    chk("skip_reload", 64'(n_irq), 64'd0);

    // continue that never releases
    wr(3'd3, 32'h0);
    stop_clk = 1;
    repeat (2) cycle();
    rel_en = 0; n_irq = 0;
    wr(3'd4, 32'h1);
    repeat (3) cycle();
    chk("fail_irq", 64'(n_irq), 64'd1);
    rd(3'd5, d);
    chk("status_fail", {32'b0, d}, 64'h0006_0003);
    wr(3'd5, 32'h0);
    rd(3'd5, d);
    chk("status_clr", {32'b0, d}, 64'h0000_0001);

    // continue in RUN ignored, then reset mid-continue
    rel_en = 1;
    wr(3'd4, 32'h1);
    repeat (3) cycle();
    n_bc = 0;
    wr(3'd4, 32'h1);
    repeat (3) cycle();
    chk("run_cmd_ign", 64'(n_bc), 64'd0);
    wr(3'd3, 32'h1);
    stop_clk = 1;
    cycle();
    chk("cont_entry", {63'b0, break_continue}, 64'd1);
    reset = 1;
    cycle();
    chk("reset_bc", {63'b0, break_continue}, 64'd0);
    reset = 0; stop_clk = 0;
    rd(3'd5, d);
    chk("reset_status", {32'b0, d}, 64'd0);
    rd(3'd3, d);
    chk("reset_skip", {32'b0, d}, 64'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      reg_we = 0; reg_re = 0;
      r = $urandom_range(0, 9);
      reg_addr = 3'($urandom_range(0, 7));
      if (reg_addr == 3'd5 && $urandom_range(0, 3) != 0)
        reg_addr = 3'd4;
      if (r < 2) begin
        reg_we = 1;
        reg_wdata = $urandom;
        if (reg_addr == 3'd3)
          reg_wdata = $urandom_range(0, 3);
        if (r == 1) reg_re = 1;
      end else if (r < 5) begin
        reg_re = 1;
      end
      if (!break_continue)
        rel_en = ($urandom_range(0, 5) != 0);
      if (!stop_clk && !break_continue && !prev_bc &&
          $urandom_range(0, 7) == 0)
        stop_clk = 1;
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 0; reg_we = 0; reg_re = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
